hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: MAX_WAIT, default 8, memory wait cycles before timeout; CNT_W, default 16, statistics counter width.
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge.
 reset  in  1  asynchronous active-low reset.
 MemRead_EX  in  1  EX-stage instruction is a load.
 rt_EX  in  5  load destination register in EX.
 rs_ID, rt_ID  in  5 each  ID-stage source registers.
 UsesRt_ID  in  1  ID instruction reads rt.
 BranchTaken_EX  in  1  branch in EX resolved taken.
 Jump_ID  in  1  jump decoded in ID.
 MemReq_MEM  in  1  MEM stage issues data-memory access.
 MemReady_MEM  in  1  data memory completes access this cycle.
 clr_cnt  in  1  synchronous clear of counters and timeout flag.
 PCWrite  out  1  PC update enable.
 IFIDWrite  out  1  IF/ID register update enable.
 flush_IFID  out  1  IF/ID load-zero request.
 flush_IDEX  out  1  ID/EX bubble request, sampled on next edge.
 pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
 mem_timeout  out  1  sticky: wait exceeded MAX_WAIT.
 stall_count  out  CNT_W  cycles with PCWrite=0.
 flush_count  out  CNT_W  cycles with any flush asserted.
 state  out  2  current FSM state.

Function
REQ-003 SHALL derive control outputs combinationally from registered state and current inputs; pipeline registers see them before the next edge.
REQ-004 SHALL use FSM states RUN=0, LU_BUBBLE=1, MEM_WAIT=2; encoding 3 unused and SHALL return to RUN.
REQ-005 Memory wait = MemReq_MEM && !MemReady_MEM; SHALL have top priority: pipe_hold=1, PCWrite=0, IFIDWrite=0, both flushes 0, next state MEM_WAIT.
REQ-006 In MEM_WAIT, SHALL hold those outputs while MemReady_MEM=0; on the cycle MemReady_MEM=1, SHALL release same cycle (pipe_hold=0) and go to RUN.
REQ-007 SHALL keep wait counter: cleared on MEM_WAIT entry, +1 per MEM_WAIT cycle, saturating; mem_timeout SHALL set on the edge where the counter reaches MAX_WAIT and stay 1 until clr_cnt or reset.
REQ-008 Without memory wait, BranchTaken_EX=1 SHALL give flush_IFID=1, flush_IDEX=1, PCWrite=1, IFIDWrite=1, overriding load-use and jump.
REQ-009 Load-use = MemRead_EX && rt_EX!=0 && (rt_EX==rs_ID || (UsesRt_ID && rt_EX==rt_ID)); in RUN without branch or memory wait, SHALL give PCWrite=0, IFIDWrite=0, flush_IDEX=1, next state LU_BUBBLE.
REQ-010 In LU_BUBBLE, SHALL mask load-use for exactly one cycle then return to RUN; branch and memory wait remain honoured.
REQ-011 Jump_ID=1 with no higher-priority event SHALL give flush_IFID=1 only; a jump under load-use stall SHALL be re-evaluated next cycle.
REQ-012 Idle default: PCWrite=1, IFIDWrite=1, flushes 0, pipe_hold=0.
REQ-013 stall_count SHALL +1 each cycle PCWrite=0; flush_count SHALL +1 each cycle flush_IFID||flush_IDEX; both saturate at all-ones.
REQ-014 clr_cnt=1 SHALL zero counters and mem_timeout on the edge, taking precedence over increment; FSM unaffected.

Reset
REQ-015 reset=0 SHALL immediately force state=RUN, wait counter=0, stall_count=0, flush_count=0, mem_timeout=0, regardless of clk.
REQ-016 Reset mid-MEM_WAIT or LU_BUBBLE SHALL abandon it; outputs then follow REQ-012 for deasserted inputs.

Structure
REQ-017 State encodings, widths and MAX_WAIT/CNT_W defaults SHALL live in shared package hazard_pkg.
REQ-018 Counters SHALL use one sub-module sat_counter (width parameter, inc, clr), instanced for stall_count, flush_count and wait counter.

Verification
REQ-019 Load-use: MemRead_EX=1, rt_EX=5, rs_ID=5 -> one cycle PCWrite=0, flush_IDEX=1, state 1 then 0; stall_count=1.
REQ-020 Branch over load-use: BranchTaken_EX=1 with REQ-019 hazard -> flush_IFID=1, flush_IDEX=1, PCWrite=1; flush_count=1, stall_count=0.
REQ-021 Memory wait: MemReq_MEM=1, MemReady_MEM=0 for 3 cycles then 1 -> pipe_hold=1 for 3 cycles, released in ready cycle, stall_count=3, mem_timeout=0.
REQ-022 Timeout: MemReady_MEM=0 for 10 cycles, MAX_WAIT=8 -> mem_timeout=1 after 8th wait edge; stays 1 after ready; clr_cnt pulse clears it and counters.
REQ-023 Async reset: reset=0 mid-MEM_WAIT between edges -> state=0, counters 0 immediately; rt_EX=0 load with rs_ID=0 -> no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller.
// Contents:
//   - default parameter values (wait limit, counter width)
//   - register-index width
//   - FSM state type
//   - helper that sizes the wait counter
package hazard_pkg;

  localparam int MAX_WAIT_DEF = 8;
  localparam int CNT_W_DEF    = 16;
  localparam int REG_W        = 5;
  localparam int STATE_W      = 2;

  // Encoding 2'd3 is deliberately left unnamed; the FSM recovers from it.
  typedef enum logic [STATE_W-1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  // Wait counter must be able to hold the value max_wait itself.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset (count -> 0)
//   inc   : add one this edge unless already all-ones
//   clr   : zero the count this edge; wins over inc
//   count : current value
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Control outputs are combinational from the registered FSM state and
// the current-cycle inputs.
//
// Event priority, highest first:
//   1. memory wait
//   2. taken branch
//   3. load-use (masked while in LU_BUBBLE)
//   4. jump
//
// Ports:
//   clk, reset                  : clock, async active-low reset
//   MemRead_EX, rt_EX           : load in EX and its destination register
//   rs_ID, rt_ID, UsesRt_ID     : ID-stage sources, rt-use qualifier
//   BranchTaken_EX, Jump_ID     : control-flow events
//   MemReq_MEM, MemReady_MEM    : data-memory handshake
//   clr_cnt                     : sync clear of statistics and timeout flag
//   PCWrite, IFIDWrite          : front-end update enables
//   flush_IFID, flush_IDEX      : flush / bubble requests
//   pipe_hold                   : freeze the back-end pipeline registers
//   mem_timeout                 : sticky wait-limit-exceeded flag
//   stall_count, flush_count    : statistics counters
//   state                       : current FSM state
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] rt_EX,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             UsesRt_ID,
  input  logic             BranchTaken_EX,
  input  logic             Jump_ID,
  input  logic             MemReq_MEM,
  input  logic             MemReady_MEM,
  input  logic             clr_cnt,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam int WAIT_W = wait_cnt_w(MAX_WAIT);

  state_t              state_q, state_d;
  logic                lu_hazard;
  logic                mem_stall;
  logic [WAIT_W-1:0]   wait_cnt;

  assign lu_hazard = MemRead_EX && (rt_EX != '0) &&
                     ((rt_EX == rs_ID) || (UsesRt_ID && (rt_EX == rt_ID)));

  // Once waiting, only MemReady_MEM releases the hold.
  assign mem_stall = (state_q == MEM_WAIT) ? !MemReady_MEM
                                           : (MemReq_MEM && !MemReady_MEM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    pipe_hold  = 1'b0;
    state_d    = RUN;
    case (state_q)
      RUN, LU_BUBBLE, MEM_WAIT: begin
        if (mem_stall) begin
          pipe_hold = 1'b1;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          state_d   = MEM_WAIT;
        end else if (BranchTaken_EX) begin
          flush_IFID = 1'b1;
          flush_IDEX = 1'b1;
        end else if (lu_hazard && (state_q != LU_BUBBLE)) begin
          // A jump in ID under this stall is simply seen again next cycle.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          flush_IDEX = 1'b1;
          state_d    = LU_BUBBLE;
        end else if (Jump_ID) begin
          flush_IFID = 1'b1;
        end
      end
      default: ; // unused encoding: idle outputs, back to RUN
    endcase
  end

  // The wait counter tracks consecutive wait cycles: any non-wait cycle
  // clears it, so it always starts from zero on entry to MEM_WAIT.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_stall),
    .clr   (clr_cnt || !mem_stall),
    .count (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!PCWrite),
    .clr   (clr_cnt),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_IFID || flush_IDEX),
    .clr   (clr_cnt),
    .count (flush_count)
  );

  // Sets on the edge where the wait counter steps onto MAX_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_timeout <= 1'b0;
    end else if (clr_cnt) begin
      mem_timeout <= 1'b0;
    end else if (mem_stall && (wait_cnt == WAIT_W'(MAX_WAIT - 1))) begin
      mem_timeout <= 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MAXW = 8;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  logic reset;
  logic mr, uses, br, jp, rq, rd, clr;
  logic [4:0] rte, rsi, rti;

  logic pc, ifid, fif, fid, hold, to;
  logic [15:0] stc, flc;
  logic [1:0] st;

  logic s_pc, s_ifid, s_fif, s_fid, s_hold, s_to;
  logic [2:0] s_stc, s_flc;
  logic [1:0] s_st;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int m_mode;    // 0 running, 1 bubble, 2 waiting on memory
  int m_stall, m_flush, m_wrun;
  bit m_to;
  bit e_pc, e_ifid, e_fif, e_fid, e_hold, e_mw;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .rt_EX(rte), .rs_ID(rsi),
    .rt_ID(rti), .UsesRt_ID(uses), .BranchTaken_EX(br), .Jump_ID(jp),
    .MemReq_MEM(rq), .MemReady_MEM(rd), .clr_cnt(clr), .PCWrite(pc),
    .IFIDWrite(ifid), .flush_IFID(fif), .flush_IDEX(fid), .pipe_hold(hold),
    .mem_timeout(to), .stall_count(stc), .flush_count(flc), .state(st)
  );

  hazard_ctrl #(.MAX_WAIT(3), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .rt_EX(rte), .rs_ID(rsi),
    .rt_ID(rti), .UsesRt_ID(uses), .BranchTaken_EX(br), .Jump_ID(jp),
    .MemReq_MEM(rq), .MemReady_MEM(rd), .clr_cnt(clr), .PCWrite(s_pc),
    .IFIDWrite(s_ifid), .flush_IFID(s_fif), .flush_IDEX(s_fid), .pipe_hold(s_hold),
    .mem_timeout(s_to), .stall_count(s_stc), .flush_count(s_flc), .state(s_st)
  );

  typedef struct {
    bit       mr;
    bit [4:0] rte, rsi, rti;
    bit       uses, br, jp, rq, rd;
    bit [4:0] ctl;   // {PCWrite, IFIDWrite, flush_IFID, flush_IDEX, pipe_hold}
    bit [1:0] nxt;   // state after the edge
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mr = 0; rte = 0; rsi = 0; rti = 0; uses = 0; br = 0; jp = 0;
    rq = 0; rd = 0; clr = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_stall = 0; m_flush = 0; m_wrun = 0; m_to = 0;
  endtask

  // Expected control outputs from the priority rules.
  task automatic model_eval();
    bit hz;
    hz = mr && (rte != 0) && ((rte == rsi) || (uses && (rte == rti)));
    e_mw = (m_mode == 2) ? !rd : (rq && !rd);
    e_pc = 1; e_ifid = 1; e_fif = 0; e_fid = 0; e_hold = 0;
    if (e_mw) begin
      e_pc = 0; e_ifid = 0; e_hold = 1;
    end else if (br) begin
      e_fif = 1; e_fid = 1;
    end else if (hz && m_mode != 1) begin
      e_pc = 0; e_ifid = 0; e_fid = 1;
    end else if (jp) begin
      e_fif = 1;
    end
  endtask

  task automatic model_update();
    bit hz;
    hz = mr && (rte != 0) && ((rte == rsi) || (uses && (rte == rti)));
    if (clr) begin
      m_stall = 0; m_flush = 0; m_wrun = 0; m_to = 0;
    end else begin
      if (!e_pc && m_stall < CMAX) m_stall++;
      if ((e_fif || e_fid) && m_flush < CMAX) m_flush++;
      m_wrun = e_mw ? m_wrun + 1 : 0;
      if (e_mw && m_wrun == MAXW) m_to = 1;
    end
    if (e_mw) m_mode = 2;
    else if (!br && hz && m_mode != 1) m_mode = 1;
    else m_mode = 0;
  endtask

  task automatic check_model(input string name);
    logic [63:0] a, e;
    model_eval();
    a = {24'd0, pc, ifid, fif, fid, hold, to, st, stc, flc};
    e = {24'd0, e_pc, e_ifid, e_fif, e_fid, e_hold, m_to, 2'(m_mode),
         16'(m_stall), 16'(m_flush)};
    chk(name, a, e);
  endtask

  // Called at posedge+1; checks at posedge+4, then advances one edge.
  task automatic settle();
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input string name);
    settle();
    check_model(name);
    tick();
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1;
    model_reset();
  endtask

  initial begin
    //          mr rte rsi rti use br jp rq rd  ctl       nxt
    tbl[0]  = '{0, 0,  0,  0,  0,  0, 0, 0, 0, 5'b11000, 2'd0};
    tbl[1]  = '{1, 5,  5,  0,  0,  0, 0, 0, 0, 5'b00010, 2'd1};
    tbl[2]  = '{1, 7,  1,  7,  1,  0, 0, 0, 0, 5'b00010, 2'd1};
    tbl[3]  = '{1, 7,  1,  7,  0,  0, 0, 0, 0, 5'b11000, 2'd0};
    tbl[4]  = '{1, 0,  0,  0,  1,  0, 0, 0, 0, 5'b11000, 2'd0};
    tbl[5]  = '{1, 5,  5,  0,  0,  1, 0, 0, 0, 5'b11110, 2'd0};
    tbl[6]  = '{0, 0,  0,  0,  0,  0, 1, 0, 0, 5'b11100, 2'd0};
    tbl[7]  = '{1, 3,  3,  0,  0,  0, 1, 0, 0, 5'b00010, 2'd1};
    tbl[8]  = '{0, 0,  0,  0,  0,  1, 0, 1, 0, 5'b00001, 2'd2};
    tbl[9]  = '{0, 0,  0,  0,  0,  0, 0, 1, 1, 5'b11000, 2'd0};
    tbl[10] = '{0, 9,  9,  9,  1,  0, 0, 0, 0, 5'b11000, 2'd0};
    tbl[11] = '{0, 0,  0,  0,  0,  1, 1, 0, 1, 5'b11110, 2'd0};

    reset = 1;
    clear_inputs();
    #1;
    do_reset();
    settle();
    chk("reset_state", {to, st, stc, flc}, 35'd0);
    tick();

    // Single-cycle decisions from the RUN state
    foreach (tbl[i]) begin
      do_reset();
      mr = tbl[i].mr; rte = tbl[i].rte; rsi = tbl[i].rsi; rti = tbl[i].rti;
      uses = tbl[i].uses; br = tbl[i].br; jp = tbl[i].jp;
      rq = tbl[i].rq; rd = tbl[i].rd;
      settle();
      chk($sformatf("tbl%0d_ctl", i), {pc, ifid, fif, fid, hold}, tbl[i].ctl);
      check_model($sformatf("tbl%0d_model", i));
      tick();
      chk($sformatf("tbl%0d_next", i), st, tbl[i].nxt);
    end

    // Load-use: exactly one stall, then the bubble masks the same hazard
    do_reset();
    mr = 1; rte = 5; rsi = 5;
    step("lu_c1");
    chk("lu_state1", st, 2'd1);
    settle();
    chk("lu_bubble_ctl", {pc, ifid, fif, fid}, 4'b1100);
    check_model("lu_c2");
    tick();
    chk("lu_state0", st, 2'd0);
    chk("lu_stall_count", stc, 16'd1);

    // Branch wins over load-use
    do_reset();
    mr = 1; rte = 5; rsi = 5; br = 1;
    step("br_lu");
    chk("br_lu_counts", {stc, flc}, {16'd0, 16'd1});

    // Memory wait of three cycles, released in the ready cycle
    do_reset();
    rq = 1; rd = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mw_hold%0d", i), hold, 1'b1);
      check_model("mw_wait");
      tick();
    end
    rd = 1;
    settle();
    chk("mw_release", {hold, pc, st}, {1'b0, 1'b1, 2'd2});
    check_model("mw_ready");
    tick();
    chk("mw_after", {st, stc, to}, {2'd0, 16'd3, 1'b0});

    // Timeout: ten wait cycles; limit 8 here, 3 on the small instance
    do_reset();
    rq = 1; rd = 0;
    for (int i = 1; i <= 10; i++) begin
      step("to_wait");
      if (i == 2) chk("small_to_before", s_to, 1'b0);
      if (i == 3) chk("small_to_at", s_to, 1'b1);
      if (i == 7) chk("to_before", to, 1'b0);
      if (i == 8) chk("to_at", to, 1'b1);
    end
    chk("small_stall_sat", s_stc, 3'd7);
    rd = 1;
    step("to_ready");
    chk("to_sticky", to, 1'b1);
    rq = 0; rd = 0; clr = 1;
    step("to_clr");
    clr = 0;
    chk("to_cleared", {to, stc, flc, s_to, s_stc}, {1'b0, 32'd0, 1'b0, 3'd0});

    // Asynchronous reset between edges while waiting
    do_reset();
    rq = 1; rd = 0;
    step("ar_w1");
    step("ar_w2");
    #3;
    reset = 0;
    #1;
    chk("ar_immediate", {st, to, stc, flc}, 35'd0);
    clear_inputs();
    #1;
    chk("ar_idle", {pc, ifid, fif, fid, hold}, 5'b11000);
    @(posedge clk);
    #1;
    reset = 1;
    model_reset();
    mr = 1; rte = 0; rsi = 0;
    settle();
    chk("r0_no_stall", pc, 1'b1);
    check_model("r0_model");
    tick();

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      mr   = 1'($urandom_range(0, 1));
      rte  = 5'($urandom_range(0, 3));
      rsi  = 5'($urandom_range(0, 3));
      rti  = 5'($urandom_range(0, 3));
      uses = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 7) == 0);
      jp   = ($urandom_range(0, 3) == 0);
      rq   = ($urandom_range(0, 2) == 0);
      rd   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
